i2s_wb_regfile_mc: RTL and testbench
====================================

// Module: i2s_wb_regfile_mc
// PURPOSE
//  Wishbone slave register file for the multi-channel PSoC audio IP; successor of the stereo regfile.
//  Stages NUM_CH samples of SAMPLE_W bits and commits them atomically to the audio FIFO via valid/ready.
//  Adds back-pressure (stall), sticky IRQ status (W1C), saturating underrun counter and one irq line.
// PARAMETERS
//  NUM_CH         2   audio channels, 1..8
//  SAMPLE_W       24  bits per sample, 8..24
//  FIFO_LEN_BITS  4   FIFO depth = 2**FIFO_LEN_BITS; level/threshold are FIFO_LEN_BITS+1 bits wide
// PORTS
//  clk             in   1                     clock
//  rst             in   1                     reset, synchronous, active-high
//  wb_sel_i        in   4                     byte enables
//  wb_dat_i        in   32                    write data
//  wb_adr_i        in   32                    byte address; only [7:0] decoded
//  wb_stb_i        in   1                     strobe
//  wb_we_i         in   1                     write enable
//  wb_dat_o        out  32                    read data, valid with ack
//  wb_ack_o        out  1                     ack, 1 cycle after accepted strobe
//  wb_stall_o      out  1                     stall (combinational)
//  audio_data      out  NUM_CH*SAMPLE_W       committed frame; ch0 in LSBs
//  audio_valid     out  1                     frame pending
//  audio_ready     in   1                     FIFO accepts frame
//  fifo_full/empty/low in 1 each              FIFO flags
//  fifo_level      in   FIFO_LEN_BITS+1       FIFO fill count
//  underrun_i      in   1                     1-cycle pulse: I2S/DAC read from empty FIFO
//  fifo_threshold  out  FIFO_LEN_BITS+1       FIFO_LOW register
//  dac_mode, dac_enable, i2s_enable, software_rst  out 1 each  CTRL0 bits 1,2,3,0
//  irq             out  1                     registered interrupt
// BEHAVIOUR
//  Map: 0x00 CTRL0 RW [5:0]: 0 swrst,1 dac_mode,2 dac_en,3 i2s_en,4 irq_en_low,5 irq_en_underrun
//   0x04 STAT0 RO {pending,full,empty,low}; 0x08 FIFO_LOW RW; 0x0C FIFO_LEVEL RO
//   0x10 IRQ_STAT W1C [1:0]: 0 low-event, 1 underrun; 0x14 UNDERRUN_CNT RO 16b
//   0x40+4*c AUDIO_CH[c] WO: [SAMPLE_W-1:0] sample, bit31 commit; c>=NUM_CH unmapped
//  Reset (rst): all registers, staging, audio_data, audio_valid, irq, ack = 0; fifo_threshold = 0.
//  WB: accept = stb & !stall; ack <= accept, 1-cycle latency; reads registered, unmapped read 0;
//   unmapped/RO writes ignored but acked; byte lanes honoured per wb_sel_i, bits >= SAMPLE_W dropped.
//  Stall = stb & we & AUDIO_CH addr & sel[3] & dat[31] & audio_valid & !audio_ready; else 0.
//  Commit (accepted, sel[3] & dat[31]): audio_data <= staging with the same write's bytes merged;
//   audio_valid <= 1 next cycle; held, data stable, until audio_valid & audio_ready, then 0.
//   Commit in cycle where pending frame is accepted (ready=1): no stall, new frame loads, valid stays 1.
//  Staging writes without commit never stall; staging retained after commit.
//  software_rst=1: audio_valid and staging forced 0 each cycle; commits accepted but dropped; CSRs kept.
//  IRQ_STAT[0] set on rising edge of fifo_low (registered prev); [1] set on underrun_i.
//   Set and W1C same cycle: set wins. UNDERRUN_CNT +1 per underrun_i, saturates 0xFFFF,
//   cleared by W1C of IRQ_STAT bit1 (increment wins if simultaneous: counter = 1).
//  irq <= |(IRQ_STAT & CTRL0[5:4]), one-cycle latency.
// STRUCTURE
//  Package i2s_pkg: register offsets, CTRL0/IRQ bit indices, AUDIO_CH base 0x40, CNT width 16.
//  Sub-module i2s_sample_stage: per-channel staging regs + output frame register with valid/ready.
// TESTING
//  Reset: assert rst 2 cycles -> all outputs 0; read 0x00/0x10/0x14 -> 0.
//  NUM_CH=2: write 0x40=0x00123456, 0x44=0x80ABCDEF, ready=0 -> audio_data=0xABCDEF_123456, valid=1 held.
//  Pending, ready=0, commit to 0x44 -> wb_stall_o=1; ready=1 one cycle -> stall drops, ack next, new frame valid.
//  fifo_low 0->1 with CTRL0=0x10 -> IRQ_STAT=0x1, irq=1; write 0x10=0x1 -> irq=0 two cycles later.
//  70000 underrun_i pulses -> UNDERRUN_CNT=0xFFFF; W1C 0x10=0x2 with simultaneous pulse -> cnt=1, bit1 set.
//  CTRL0=0x1 then commit -> audio_valid stays 0; sel=4'b0001 write to 0x40 only changes ch0 bits[7:0].

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared register map, bit positions and helpers for the multi-channel I2S register file.
package i2s_pkg;

  // Byte offsets of the CSRs; only address bits [7:2] select a register.
  localparam logic [7:0] ADDR_CTRL0        = 8'h00;
  localparam logic [7:0] ADDR_STAT0        = 8'h04;
  localparam logic [7:0] ADDR_FIFO_LOW     = 8'h08;
  localparam logic [7:0] ADDR_FIFO_LEVEL   = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_STAT     = 8'h10;
  localparam logic [7:0] ADDR_UNDERRUN_CNT = 8'h14;
  localparam logic [7:0] AUDIO_CH_BASE     = 8'h40;

  // CTRL0 bit positions.
  localparam int CTRL_W               = 6;
  localparam int CTRL_SWRST           = 0;
  localparam int CTRL_DAC_MODE        = 1;
  localparam int CTRL_DAC_EN          = 2;
  localparam int CTRL_I2S_EN          = 3;
  localparam int CTRL_IRQ_EN_LOW      = 4;
  localparam int CTRL_IRQ_EN_UNDERRUN = 5;

  // IRQ_STAT bit positions.
  localparam int IRQ_W        = 2;
  localparam int IRQ_LOW      = 0;
  localparam int IRQ_UNDERRUN = 1;

  localparam int CNT_W      = 16;
  localparam int COMMIT_BIT = 31;

  // Replace the bytes of old_val whose byte enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/i2s_wb_regfile_mc_if.sv
// Wishbone classic-pipelined slave bus bundle (with stall) for the I2S register file.
interface i2s_wb_regfile_mc_if;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_adr_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;

  modport master (
    output wb_sel_i, wb_dat_i, wb_adr_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_sel_i, wb_dat_i, wb_adr_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/i2s_sample_stage.sv
// Per-channel sample staging registers and the committed output frame with valid/ready.
module i2s_sample_stage #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       swrst,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_ch,
  input  logic [31:0]                wr_data,
  input  logic [3:0]                 wr_sel,
  input  logic                       commit,
  input  logic                       audio_ready,
  output logic [NUM_CH*SAMPLE_W-1:0] audio_data,
  output logic                       audio_valid
);
  import i2s_pkg::*;

  logic [SAMPLE_W-1:0]        stage_q   [NUM_CH];
  logic [SAMPLE_W-1:0]        stage_nxt [NUM_CH];
  logic [NUM_CH*SAMPLE_W-1:0] frame_nxt;

  // Byte-merge a bus write into one sample; bits above SAMPLE_W are dropped.
  function automatic logic [SAMPLE_W-1:0] merge_sample(input logic [SAMPLE_W-1:0] old_s,
                                                       input logic [31:0]         dat,
                                                       input logic [3:0]          sel);
    logic [31:0] m;
    m = byte_merge({{(32-SAMPLE_W){1'b0}}, old_s}, dat, sel);
    return m[SAMPLE_W-1:0];
  endfunction

  // Next staging contents; the committed frame includes the committing write's own bytes.
  always_comb begin
    frame_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      stage_nxt[c] = (wr_en && wr_ch == 3'(c)) ? merge_sample(stage_q[c], wr_data, wr_sel)
                                                : stage_q[c];
      frame_nxt[c*SAMPLE_W +: SAMPLE_W] = stage_nxt[c];
    end
  end

  // Staging registers; software reset keeps them cleared every cycle.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      stage_q[c] <= (rst || swrst) ? '0 : stage_nxt[c];
    end
  end

  // Output frame: loads on commit, held stable until the FIFO takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_data  <= '0;
      audio_valid <= 1'b0;
    end else if (swrst) begin
      audio_valid <= 1'b0;
    end else if (commit) begin
      audio_data  <= frame_nxt;
      audio_valid <= 1'b1;
    end else if (audio_valid && audio_ready) begin
      audio_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_wb_regfile_mc.sv
// Wishbone register file for the multi-channel audio IP: CSRs, sticky IRQs, underrun counter.
module i2s_wb_regfile_mc #(
  parameter int NUM_CH        = 2,
  parameter int SAMPLE_W      = 24,
  parameter int FIFO_LEN_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  i2s_wb_regfile_mc_if.slave         wb,
  output logic [NUM_CH*SAMPLE_W-1:0] audio_data,
  output logic                       audio_valid,
  input  logic                       audio_ready,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  input  logic                       fifo_low,
  input  logic [FIFO_LEN_BITS:0]     fifo_level,
  input  logic                       underrun_i,
  output logic [FIFO_LEN_BITS:0]     fifo_threshold,
  output logic                       dac_mode,
  output logic                       dac_enable,
  output logic                       i2s_enable,
  output logic                       software_rst,
  output logic                       irq
);
  import i2s_pkg::*;

  localparam int                 LVL_W    = FIFO_LEN_BITS + 1;
  localparam logic [3:0]         NUM_CH_L = 4'(NUM_CH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]        addr;
  logic [5:0]        word;
  logic              is_audio;
  logic              commit_req;
  logic              stall;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic [CTRL_W-1:0] ctrl0;
  logic [IRQ_W-1:0]  irq_stat;
  logic [IRQ_W-1:0]  irq_clr;
  logic [CNT_W-1:0]  underrun_cnt;
  logic              fifo_low_p1;
  logic              low_event;
  logic [31:0]       rdata;
  logic [31:0]       thr_merged;
  logic              unused_ok;

  // Saturating increment for the underrun counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign addr       = wb.wb_adr_i[7:0];
  assign word       = addr[7:2];
  assign is_audio   = (addr[7:6] == AUDIO_CH_BASE[7:6]) && (addr[5:2] < NUM_CH_L);
  assign commit_req = wb.wb_stb_i && wb.wb_we_i && is_audio
                      && wb.wb_sel_i[3] && wb.wb_dat_i[COMMIT_BIT];
  // Only a commit that would overwrite a frame the FIFO has not yet taken must wait.
  assign stall      = commit_req && audio_valid && !audio_ready;
  assign accept     = wb.wb_stb_i && !stall;
  assign wr_acc     = accept && wb.wb_we_i;
  assign rd_acc     = accept && !wb.wb_we_i;
  assign wb.wb_stall_o = stall;

  assign low_event  = fifo_low && !fifo_low_p1;
  assign irq_clr    = (wr_acc && word == ADDR_IRQ_STAT[7:2] && wb.wb_sel_i[0])
                      ? wb.wb_dat_i[IRQ_W-1:0] : '0;
  assign thr_merged = byte_merge({{(32-LVL_W){1'b0}}, fifo_threshold}, wb.wb_dat_i, wb.wb_sel_i);

  assign software_rst = ctrl0[CTRL_SWRST];
  assign dac_mode     = ctrl0[CTRL_DAC_MODE];
  assign dac_enable   = ctrl0[CTRL_DAC_EN];
  assign i2s_enable   = ctrl0[CTRL_I2S_EN];

  assign unused_ok = ^{wb.wb_adr_i[31:8], addr[1:0]};

  i2s_sample_stage #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W)
  ) u_stage (
    .clk         (clk),
    .rst         (rst),
    .swrst       (ctrl0[CTRL_SWRST]),
    .wr_en       (wr_acc && is_audio),
    .wr_ch       (addr[4:2]),
    .wr_data     (wb.wb_dat_i),
    .wr_sel      (wb.wb_sel_i),
    .commit      (accept && commit_req),
    .audio_ready (audio_ready),
    .audio_data  (audio_data),
    .audio_valid (audio_valid)
  );

  // Writable CSRs; RO and unmapped offsets are silently ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl0          <= '0;
      fifo_threshold <= '0;
    end else if (wr_acc) begin
      if (word == ADDR_CTRL0[7:2] && wb.wb_sel_i[0]) ctrl0 <= wb.wb_dat_i[CTRL_W-1:0];
      if (word == ADDR_FIFO_LOW[7:2]) fifo_threshold <= thr_merged[LVL_W-1:0];
    end
  end

  // Sticky event flags and underrun counter; a new event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_low_p1  <= 1'b0;
      irq_stat     <= '0;
      underrun_cnt <= '0;
    end else begin
      fifo_low_p1             <= fifo_low;
      irq_stat[IRQ_LOW]       <= low_event  || (irq_stat[IRQ_LOW] && !irq_clr[IRQ_LOW]);
      irq_stat[IRQ_UNDERRUN]  <= underrun_i || (irq_stat[IRQ_UNDERRUN] && !irq_clr[IRQ_UNDERRUN]);
      if (underrun_i)
        underrun_cnt <= irq_clr[IRQ_UNDERRUN] ? CNT_ONE : sat_inc(underrun_cnt);
      else if (irq_clr[IRQ_UNDERRUN])
        underrun_cnt <= '0;
    end
  end

  // Registered interrupt line from enabled status bits.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(irq_stat & ctrl0[CTRL_IRQ_EN_UNDERRUN:CTRL_IRQ_EN_LOW]);
  end

  // Read data selection.
  always_comb begin
    rdata = '0;
    case (word)
      ADDR_CTRL0[7:2]:        rdata[CTRL_W-1:0] = ctrl0;
      ADDR_STAT0[7:2]:        rdata[3:0]        = {audio_valid, fifo_full, fifo_empty, fifo_low};
      ADDR_FIFO_LOW[7:2]:     rdata[LVL_W-1:0]  = fifo_threshold;
      ADDR_FIFO_LEVEL[7:2]:   rdata[LVL_W-1:0]  = fifo_level;
      ADDR_IRQ_STAT[7:2]:     rdata[IRQ_W-1:0]  = irq_stat;
      ADDR_UNDERRUN_CNT[7:2]: rdata[CNT_W-1:0]  = underrun_cnt;
      default:                rdata = '0;
    endcase
  end

  // Bus response: ack and read data one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= accept;
      wb.wb_dat_o <= rd_acc ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_i2s_wb_regfile_mc.sv
// Directed plus randomized bench for i2s_wb_regfile_mc with a behavioural model.
module tb_i2s_wb_regfile_mc;
  localparam int NUM_CH        = 2;
  localparam int SAMPLE_W      = 24;
  localparam int FIFO_LEN_BITS = 4;
  localparam int LVL_W         = FIFO_LEN_BITS + 1;
  localparam int FW            = NUM_CH * SAMPLE_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_wb_regfile_mc_if bus();

  logic [FW-1:0]    audio_data;
  logic             audio_valid, audio_ready;
  logic             fifo_full, fifo_empty, fifo_low, underrun_i;
  logic [LVL_W-1:0] fifo_level, fifo_threshold;
  logic             dac_mode, dac_enable, i2s_enable, software_rst, irq;

  i2s_wb_regfile_mc #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .FIFO_LEN_BITS(FIFO_LEN_BITS)
  ) dut (
    .clk(clk), .rst(rst), .wb(bus),
    .audio_data(audio_data), .audio_valid(audio_valid), .audio_ready(audio_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_low(fifo_low),
    .fifo_level(fifo_level), .underrun_i(underrun_i), .fifo_threshold(fifo_threshold),
    .dac_mode(dac_mode), .dac_enable(dac_enable), .i2s_enable(i2s_enable),
    .software_rst(software_rst), .irq(irq)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [SAMPLE_W-1:0] m_stage [NUM_CH];
  logic [FW-1:0]       m_frame;
  logic [LVL_W-1:0]    m_thr;
  int                  m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int c = 0; c < NUM_CH; c++) f[c*SAMPLE_W +: SAMPLE_W] = m_stage[c];
    return f;
  endfunction

  task automatic model_write(input int ch, input logic [31:0] dat, input logic [3:0] sel);
    if (ch >= NUM_CH) return;
    for (int b = 0; b < SAMPLE_W / 8; b++)
      if (sel[b]) m_stage[ch][8*b +: 8] = dat[8*b +: 8];
    if (sel[3] && dat[31]) m_frame = model_frame();
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int n;
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = {24'd0, adr}; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
    #1;
    n = 0;
    while (bus.wb_stall_o === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_stall_bound", 64'(bus.wb_stall_o), 64'd0);
    @(negedge clk);
    check("wr_ack", 64'(bus.wb_ack_o), 64'd1);
    bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = {24'd0, adr}; bus.wb_sel_i = 4'hF;
    @(negedge clk);
    check("rd_ack", 64'(bus.wb_ack_o), 64'd1);
    dat = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ch;
    int          k;
    bit          cmt;

    bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    audio_ready = 0; fifo_full = 0; fifo_empty = 0; fifo_low = 0; fifo_level = '0; underrun_i = 0;
    for (int c = 0; c < NUM_CH; c++) m_stage[c] = '0;
    m_frame = '0; m_thr = '0; m_cnt = 0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_audio_data", 64'(audio_data), 64'd0);
    check("rst_audio_valid", 64'(audio_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_ack", 64'(bus.wb_ack_o), 64'd0);
    check("rst_threshold", 64'(fifo_threshold), 64'd0);
    check("rst_ctrl_outs", 64'({i2s_enable, dac_enable, dac_mode, software_rst}), 64'd0);
    wb_read(8'h00, rd); check("rst_rd_ctrl0", 64'(rd), 64'd0);
    wb_read(8'h10, rd); check("rst_rd_irq_stat", 64'(rd), 64'd0);
    wb_read(8'h14, rd); check("rst_rd_cnt", 64'(rd), 64'd0);

    // Basic stage + commit, frame held while FIFO not ready
    wb_write(8'h40, 32'h0012_3456, 4'hF); model_write(0, 32'h0012_3456, 4'hF);
    wb_write(8'h44, 32'h80AB_CDEF, 4'hF); model_write(1, 32'h80AB_CDEF, 4'hF);
    check("commit_data", 64'(audio_data), 64'h0000_ABCD_EF12_3456);
    check("commit_valid", 64'(audio_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("held_data", 64'(audio_data), 64'(m_frame));
    check("held_valid", 64'(audio_valid), 64'd1);

    // Back-pressure on a second commit
    @(negedge clk);
    bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_adr_i = 32'h44; bus.wb_dat_i = 32'h8000_0111; bus.wb_sel_i = 4'hF;
    #1;
    check("stall_on", 64'(bus.wb_stall_o), 64'd1);
    @(negedge clk);
    check("stall_still", 64'(bus.wb_stall_o), 64'd1);
    check("stall_data_stable", 64'(audio_data), 64'(m_frame));
    audio_ready = 1'b1;
    #1;
    check("stall_drop", 64'(bus.wb_stall_o), 64'd0);
    @(negedge clk);
    model_write(1, 32'h8000_0111, 4'hF);
    check("stall_ack", 64'(bus.wb_ack_o), 64'd1);
    check("swap_valid", 64'(audio_valid), 64'd1);
    check("swap_data", 64'(audio_data), 64'h0000_0001_1112_3456);
    bus.wb_stb_i = 0; bus.wb_we_i = 0; audio_ready = 1'b0;
    @(negedge clk);
    audio_ready = 1'b1;
    @(negedge clk);
    audio_ready = 1'b0;
    check("drain_valid", 64'(audio_valid), 64'd0);
    check("drain_data", 64'(audio_data), 64'(m_frame));

    // Status, level and threshold registers
    fifo_full = 1; fifo_empty = 0; fifo_level = 5'd16;
    wb_read(8'h04, rd); check("stat0", 64'(rd), 64'h4);
    wb_read(8'h0C, rd); check("fifo_level", 64'(rd), 64'd16);
    wb_write(8'h08, 32'h0000_001F, 4'b0001); m_thr = 5'h1F;
    check("thr_out", 64'(fifo_threshold), 64'(m_thr));
    wb_write(8'h08, 32'hFFFF_FF00, 4'b1110);
    wb_read(8'h08, rd); check("thr_lanes", 64'(rd), 64'(m_thr));
    wb_write(8'h0C, 32'hFFFF_FFFF, 4'hF);
    wb_read(8'h0C, rd); check("ro_write_ignored", 64'(rd), 64'd16);
    wb_write(8'h00, 32'h0000_000E, 4'hF);
    check("ctrl_outs", 64'({i2s_enable, dac_enable, dac_mode, software_rst}), 64'hE);

    // Low-level interrupt and W1C
    wb_write(8'h00, 32'h0000_0010, 4'hF);
    @(negedge clk); fifo_low = 1'b1;
    repeat (2) @(negedge clk);
    check("irq_low_set", 64'(irq), 64'd1);
    wb_read(8'h10, rd); check("irq_stat_low", 64'(rd), 64'h1);
    wb_write(8'h10, 32'h1, 4'hF);
    check("irq_lag", 64'(irq), 64'd1);
    @(negedge clk);
    check("irq_cleared", 64'(irq), 64'd0);
    wb_read(8'h10, rd); check("irq_stat_cleared", 64'(rd), 64'h0);

    // Saturating underrun counter
    @(negedge clk); underrun_i = 1'b1;
    repeat (70000) @(negedge clk);
    underrun_i = 1'b0;
    m_cnt = (70000 > 65535) ? 65535 : 70000;
    wb_read(8'h14, rd); check("cnt_saturate", 64'(rd), 64'(m_cnt));
    wb_read(8'h10, rd); check("irq_stat_underrun", 64'(rd), 64'h2);
    check("irq_masked", 64'(irq), 64'd0);
    wb_write(8'h00, 32'h0000_0020, 4'hF);
    repeat (2) @(negedge clk);
    check("irq_underrun", 64'(irq), 64'd1);
    @(negedge clk);
    bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_adr_i = 32'h10; bus.wb_dat_i = 32'h2; bus.wb_sel_i = 4'hF;
    underrun_i = 1'b1;
    @(negedge clk);
    check("w1c_race_ack", 64'(bus.wb_ack_o), 64'd1);
    bus.wb_stb_i = 0; bus.wb_we_i = 0; underrun_i = 1'b0;
    m_cnt = 1;
    wb_read(8'h14, rd); check("cnt_race", 64'(rd), 64'(m_cnt));
    wb_read(8'h10, rd); check("stat_race", 64'(rd), 64'h2);
    wb_write(8'h10, 32'h2, 4'hF); m_cnt = 0;
    wb_read(8'h14, rd); check("cnt_clear", 64'(rd), 64'(m_cnt));
    wb_read(8'h10, rd); check("stat_clear", 64'(rd), 64'h0);
    check("irq_off", 64'(irq), 64'd0);

    // Software reset drops commits and clears staging
    wb_write(8'h00, 32'h0000_0001, 4'b0001);
    check("swrst_out", 64'(software_rst), 64'd1);
    for (int c = 0; c < NUM_CH; c++) m_stage[c] = '0;
    wb_write(8'h40, 32'h8055_5555, 4'hF);
    @(negedge clk);
    check("swrst_valid", 64'(audio_valid), 64'd0);
    check("swrst_data", 64'(audio_data), 64'(m_frame));
    wb_write(8'h00, 32'h0, 4'b0001);
    wb_write(8'h44, 32'h8000_0000, 4'b1000); model_write(1, 32'h8000_0000, 4'b1000);
    check("post_swrst_valid", 64'(audio_valid), 64'd1);
    check("post_swrst_data", 64'(audio_data), 64'(m_frame));

    // Byte-lane write to ch0 only
    audio_ready = 1'b1;
    wb_write(8'h40, 32'h00AA_BBCC, 4'hF);    model_write(0, 32'h00AA_BBCC, 4'hF);
    wb_write(8'h40, 32'h0000_0011, 4'b0001); model_write(0, 32'h0000_0011, 4'b0001);
    wb_write(8'h44, 32'h8000_0000, 4'b1000); model_write(1, 32'h8000_0000, 4'b1000);
    check("lane_ch0", 64'(audio_data[SAMPLE_W-1:0]), 64'hAA_BB11);
    check("lane_frame", 64'(audio_data), 64'(m_frame));
    wb_write(8'h48, 32'h80FF_FFFF, 4'hF);
    check("unmapped_ch", 64'(audio_data), 64'(m_frame));

    // Randomized staging, commits and threshold writes
    for (int i = 0; i < 40; i++) begin
      ch  = int'($urandom_range(0, 3));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      cmt = (ch < NUM_CH) && sel[3] && dat[31];
      wb_write(8'h40 + 8'(4 * ch), dat, sel);
      model_write(ch, dat, sel);
      check("rnd_frame", 64'(audio_data), 64'(m_frame));
      if (cmt) check("rnd_valid", 64'(audio_valid), 64'd1);
      if (i % 4 == 3) begin
        dat = $urandom;
        sel = 4'($urandom_range(0, 15));
        wb_write(8'h08, dat, sel);
        if (sel[0]) m_thr = dat[LVL_W-1:0];
        check("rnd_thr", 64'(fifo_threshold), 64'(m_thr));
      end
    end

    // Randomized sparse underrun pulses
    k = int'($urandom_range(1, 40));
    for (int p = 0; p < k; p++) begin
      @(negedge clk); underrun_i = 1'b1;
      @(negedge clk); underrun_i = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    m_cnt = k;
    wb_read(8'h14, rd); check("rnd_cnt", 64'(rd), 64'(m_cnt));
    wb_read(8'h10, rd); check("rnd_stat", 64'(rd), 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
